axi_burst_master: RTL and testbench
===================================

Name: axi_burst_master

Overview:
AXI4 master command engine that sits directly upstream of the AXI slave memory and drives its AW/W/B and AR/R channels. It accepts one burst command at a time on a valid/ready command port. Write data arrives as a beat stream; read data leaves as a beat stream. One completion pulse per command reports the merged response. It is the RTL stimulus front-end for slave-level bring-up and the future subsystem top.

Parameters:
ADDR_W, 32, address width of cmd and AXI address channels
DATA_W, 32, data bus width (32 or 64); STRB_W = DATA_W/8
ID_W, 4, AXI ID width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid/cmd_ready  in/out  1  command handshake
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  start address
cmd_len  in  8  beats minus 1 (AXI LEN)
cmd_size  in  3  bytes per beat = 2**size
cmd_burst  in  2  0 FIXED, 1 INCR, 2 WRAP (3 illegal)
cmd_id  in  ID_W  transaction ID
wd_valid/wd_ready  in/out  1  write-data stream handshake
wd_data  in  DATA_W  write beat data
rd_valid  out  1  read beat valid (no backpressure)
rd_data  out  DATA_W  read beat data
rd_last  out  1  final read beat
done  out  1  one-cycle completion pulse
done_resp  out  2  merged response
done_err  out  1  command rejected or protocol error
awid/awaddr/awlen/awsize/awburst/awvalid/awready  AXI write address (awready in)
wdata/wstrb/wlast/wvalid/wready  AXI write data (wready in)
bid/bresp/bvalid/bready  AXI write response (bready out)
arid/araddr/arlen/arsize/arburst/arvalid/arready  AXI read address (arready in)
rid/rdata/rresp/rlast/rvalid/rready  AXI read data (rready out)

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst. During rst, state = IDLE and every output = 0, except cmd_ready, which is 0 during rst and goes to 1 in the first IDLE cycle after release. Reset mid-burst abandons the transaction; no completion is reported.
- FSM states: IDLE, CHECK, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, register all cmd fields, go to CHECK.
- CHECK (1 cycle): reject the command if any of these hold:
  - size > log2(STRB_W);
  - burst == 3;
  - WRAP with len not in {1,3,7,15};
  - WRAP with addr not size-aligned;
  - INCR crossing a 4 KB boundary.
  On reject, go to DONE with done_err=1 and done_resp=2'b10; no AXI traffic is issued. Otherwise go to WR_ADDR or RD_ADDR.
- WR_ADDR / RD_ADDR: the matching xVALID rises on the cycle of entry, fields are held stable until xREADY, then the FSM moves on. W beats are never issued before the AW handshake.
- WR_DATA:
  - wvalid = wd_valid and wd_ready = wready (combinational pass-through, zero latency).
  - wstrb: lanes [beat_addr mod STRB_W, +2**size) of the current beat address.
  - wlast on beat index == len.
  - After the last handshake, go to WR_RESP.
- Beat address per handshake:
  - FIXED: unchanged.
  - INCR: add 2**size.
  - WRAP: add 2**size within the window of (len+1)*2**size bytes aligned to that size; on reaching the upper boundary, wrap to the window base.
- WR_RESP: bready=1. On bvalid, capture bresp and go to DONE. bid != awid sets done_err.
- RD_DATA:
  - rready=1; each rvalid beat is forwarded the same cycle (rd_valid=rvalid, rd_data=rdata).
  - rd_last is asserted on beat index == len, regardless of rlast.
  - rlast on any other beat, rlast missing on beat len, or rid != arid sets done_err.
  - After beat len, go to DONE. Extra R beats arriving later are ignored and are a bench error.
- Merged response: worst seen, with DECERR(3) > SLVERR(2) > OKAY(0). EXOKAY is treated as OKAY (no exclusive support).
- DONE (1 cycle): done=1, then return to IDLE. cmd_ready is 0 in every non-IDLE state, so the minimum command-to-command period for a 1-beat write with zero-wait slave is 6 cycles.
- All AXI outputs are registered except wvalid, wdata, wd_ready, rd_*, which are pass-through.

Decomposition:
- Package axi_pkg:
  - burst enums FIXED/INCR/WRAP;
  - resp enums OKAY/EXOKAY/SLVERR/DECERR;
  - FSM state typedef;
  - cmd struct;
  - function resp_max;
  - function next_beat_addr(addr, size, len, burst);
  - function strb_gen(addr, size).
- One sub-module, axi_beat_addr_gen: holds the beat address register and beat counter, and produces beat_addr, beat_idx, is_last. It is shared by the write and read paths.

Test Plan:
- Write INCR addr=0x100, len=3, size=2, data 0xA0..0xA3, zero-wait slave -> one AW (awaddr 0x100, awlen 3), four W beats all wstrb 0xF, wlast on beat 3, done with resp 0, err 0.
- Read WRAP addr=0x38, len=3, size=2 -> araddr 0x38, internal beat addrs 0x38, 0x3C, 0x30, 0x34, rd_last on 4th beat, done resp 0.
- Narrow write FIXED addr=0x1002, size=0, len=1 -> both beats wstrb 0x4, awaddr 0x1002.
- Illegal INCR addr=0xFF8, len=3, size=2 (crosses 4 KB) -> no awvalid ever, done_err=1, done_resp 2 in cycle 2 after accept.
- Read len=2, slave returns rresp OKAY, SLVERR, OKAY and asserts rlast on beat 1 -> 3 rd beats delivered, done_resp 2, done_err 1.
- Assert rst while in WR_DATA on beat 1 of 4 -> all outputs 0 immediately (asynchronous), IDLE after release, no done pulse.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared types and beat arithmetic for the AXI4 burst master.
// Helper functions work on 64-bit addresses; callers size-cast in and out.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_e;

  typedef struct packed {
    logic       write;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } cmd_t;

  localparam int PAGE_BITS = 12;

  // EXOKAY folds to OKAY; the remaining codes already rank by value.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] na;
    logic [1:0] nb;
    na = (a == EXOKAY) ? OKAY : a;
    nb = (b == EXOKAY) ? OKAY : b;
    return (na > nb) ? na : nb;
  endfunction

  function automatic logic [63:0] next_beat_addr(input logic [63:0] addr, input logic [2:0] size,
                                                 input logic [7:0] len, input logic [1:0] burst);
    logic [63:0] inc;
    logic [63:0] wsize;
    logic [63:0] base;
    inc   = addr + (64'd1 << size);
    wsize = (64'(len) + 64'd1) << size;
    base  = addr & ~(wsize - 64'd1);
    case (burst)
      INCR:    return inc;
      WRAP:    return (inc >= base + wsize) ? base : inc;
      default: return addr;
    endcase
  endfunction

  // addr is the byte lane offset of the beat within the data bus.
  function automatic logic [15:0] strb_gen(input logic [2:0] addr, input logic [2:0] size);
    return ((16'd1 << (16'd1 << size)) - 16'd1) << addr;
  endfunction

endpackage

// File: rtl/axi_beat_addr_gen.sv
// Beat address and beat index tracker shared by the write and read data phases.
module axi_beat_addr_gen import axi_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [7:0]        beat_idx,
  output logic              is_last
);

  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_next;
  logic [7:0]        idx_reg;
  logic [7:0]        idx_next;

  always_comb begin
    addr_next = addr_reg;
    idx_next  = idx_reg;
    if (load) begin
      addr_next = start_addr;
      idx_next  = 8'd0;
    end else if (advance) begin
      addr_next = ADDR_W'(next_beat_addr(64'(addr_reg), size, len, burst));
      idx_next  = idx_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg <= '0;
      idx_reg  <= '0;
    end else begin
      addr_reg <= addr_next;
      idx_reg  <= idx_next;
    end
  end

  assign beat_addr = addr_reg;
  assign beat_idx  = idx_reg;
  assign is_last   = (idx_reg == len);

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master: validates a command, runs one AW/W/B or
// AR/R burst, and reports one merged completion per command.
module axi_burst_master import axi_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic [1:0]        done_resp,
  output logic              done_err,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int SIZE_MAX = $clog2(STRB_W);

  state_e            state;
  state_e            state_next;
  cmd_t              cmd_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ID_W-1:0]   id_reg;
  logic [1:0]        resp_reg;
  logic              err_reg;
  logic              cmd_ready_reg;
  logic              awvalid_reg;
  logic              arvalid_reg;
  logic              bready_reg;
  logic              rready_reg;

  logic              accept;
  logic              w_hs;
  logic              r_hs;
  logic              reject;
  logic [63:0]       addr64;
  logic [63:0]       last_byte;
  logic [ADDR_W-1:0] beat_addr;
  logic [7:0]        beat_idx;
  logic              is_last;

  assign accept = (state == IDLE) && cmd_valid && cmd_ready_reg;
  assign w_hs   = (state == WR_DATA) && wd_valid && wready;
  assign r_hs   = (state == RD_DATA) && rvalid;

  always_comb begin
    addr64    = 64'(addr_reg);
    last_byte = addr64 + ((64'(cmd_reg.len) + 64'd1) << cmd_reg.size) - 64'd1;
    reject    = 1'b0;
    if (int'(cmd_reg.size) > SIZE_MAX) reject = 1'b1;
    if (cmd_reg.burst == 2'd3) reject = 1'b1;
    if (cmd_reg.burst == WRAP && !(cmd_reg.len inside {8'd1, 8'd3, 8'd7, 8'd15})) reject = 1'b1;
    if (cmd_reg.burst == WRAP && (addr64 & ((64'd1 << cmd_reg.size) - 64'd1)) != 64'd0) reject = 1'b1;
    if (cmd_reg.burst == INCR && (last_byte >> PAGE_BITS) != (addr64 >> PAGE_BITS)) reject = 1'b1;
  end

  axi_beat_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (state == CHECK),
    .advance    (w_hs || r_hs),
    .start_addr (addr_reg),
    .size       (cmd_reg.size),
    .len        (cmd_reg.len),
    .burst      (cmd_reg.burst),
    .beat_addr  (beat_addr),
    .beat_idx   (beat_idx),
    .is_last    (is_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    wvalid     = 1'b0;
    wdata      = '0;
    wd_ready   = 1'b0;
    wstrb      = '0;
    wlast      = 1'b0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    rd_last    = 1'b0;
    case (state)
      IDLE:    if (accept) state_next = CHECK;
      CHECK: begin
        if (reject)             state_next = DONE;
        else if (cmd_reg.write) state_next = WR_ADDR;
        else                    state_next = RD_ADDR;
      end
      WR_ADDR: if (awready) state_next = WR_DATA;
      WR_DATA: begin
        wvalid   = wd_valid;
        wdata    = wd_data;
        wd_ready = wready;
        // Strobe and last are decoded from the registered beat state only.
        wstrb    = STRB_W'(strb_gen(3'(beat_addr) & 3'(STRB_W - 1), cmd_reg.size));
        wlast    = (beat_idx == cmd_reg.len);
        if (w_hs && is_last) state_next = WR_RESP;
      end
      WR_RESP: if (bvalid) state_next = DONE;
      RD_ADDR: if (arready) state_next = RD_DATA;
      RD_DATA: begin
        rd_valid = rvalid;
        rd_data  = rdata;
        rd_last  = rvalid && is_last;
        if (r_hs && is_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_reg       <= '0;
      addr_reg      <= '0;
      id_reg        <= '0;
      resp_reg      <= OKAY;
      err_reg       <= 1'b0;
      cmd_ready_reg <= 1'b0;
      awvalid_reg   <= 1'b0;
      arvalid_reg   <= 1'b0;
      bready_reg    <= 1'b0;
      rready_reg    <= 1'b0;
    end else begin
      cmd_ready_reg <= (state_next == IDLE);
      awvalid_reg   <= (state_next == WR_ADDR);
      arvalid_reg   <= (state_next == RD_ADDR);
      bready_reg    <= (state_next == WR_RESP);
      rready_reg    <= (state_next == RD_DATA);
      if (accept) begin
        cmd_reg  <= '{write: cmd_write, len: cmd_len, size: cmd_size, burst: cmd_burst};
        addr_reg <= cmd_addr;
        id_reg   <= cmd_id;
        resp_reg <= OKAY;
        err_reg  <= 1'b0;
      end
      if (state == CHECK && reject) begin
        resp_reg <= SLVERR;
        err_reg  <= 1'b1;
      end
      if (state == WR_RESP && bvalid) begin
        resp_reg <= resp_max(resp_reg, bresp);
        if (bid != id_reg) err_reg <= 1'b1;
      end
      if (r_hs) begin
        resp_reg <= resp_max(resp_reg, rresp);
        if (rlast != is_last || rid != id_reg) err_reg <= 1'b1;
      end
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign awid      = id_reg;
  assign awaddr    = addr_reg;
  assign awlen     = cmd_reg.len;
  assign awsize    = cmd_reg.size;
  assign awburst   = cmd_reg.burst;
  assign awvalid   = awvalid_reg;
  assign arid      = id_reg;
  assign araddr    = addr_reg;
  assign arlen     = cmd_reg.len;
  assign arsize    = cmd_reg.size;
  assign arburst   = cmd_reg.burst;
  assign arvalid   = arvalid_reg;
  assign bready    = bready_reg;
  assign rready    = rready_reg;
  assign done      = (state == DONE);
  assign done_resp = done ? resp_reg : 2'b00;
  assign done_err  = done && err_reg;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: table of commands against a zero-wait
// slave model, plus a mid-burst asynchronous reset sequence.
module tb_axi_burst_master;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [3:0]  cmd_id;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rd_valid, rd_last;
  logic [31:0] rd_data;
  logic        done, done_err;
  logic [1:0]  done_resp;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .done_err(done_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [1:0]  bresp;
    logic [3:0]  bid_xor;
    logic [7:0]  rresp;      // 2 bits per read beat, beat 0 in [1:0]
    logic [3:0]  rlast_mask; // slave rlast per read beat
    int          exp_aw;
    int          exp_ar;
    logic [3:0]  exp_strb;
    int          exp_beats;
    logic [1:0]  exp_resp;
    logic        exp_err;
    int          exp_done_cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference beat address computed as offset arithmetic inside the wrap window.
  function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [2:0] sz,
                                             input logic [7:0] ln, input logic [1:0] bu, input int i);
    int unsigned n, ws, base;
    n = 1 << sz;
    case (bu)
      2'd1: return a + 32'(i * n);
      2'd2: begin
        ws   = (int'(ln) + 1) * n;
        base = (a / ws) * ws;
        return 32'(base + ((a - base) + i * n) % ws);
      end
      default: return a;
    endcase
  endfunction

  task automatic drive_cmd(input vec_t v);
    cmd_write = v.write; cmd_addr = v.addr; cmd_len = v.len;
    cmd_size  = v.size;  cmd_burst = v.burst; cmd_id = v.id;
    cmd_valid = 1'b1;
    for (int c = 0; c < 20 && !cmd_ready; c++) begin
      @(posedge clk); #1;
    end
    chk("cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int aw_n = 0, ar_n = 0, w_n = 0, r_n = 0, done_n = 0, done_cyc = -1;
    int last_n = 0, last_at = -1, rbeat = 0;
    logic [1:0]  dresp = 2'b00;
    logic        derr = 1'b0, got_done = 1'b0;
    logic [31:0] aaddr = '0;
    logic [7:0]  alen = '0;
    logic        aw_h, w_h, b_h, ar_h, r_h, w_l;
    wd_data = 32'hA0;
    drive_cmd(v);
    for (int cyc = 1; cyc <= 60 && !got_done; cyc++) begin
      @(negedge clk);
      aw_h = awvalid && awready;
      ar_h = arvalid && arready;
      w_h  = wvalid && wready;
      w_l  = wlast;
      b_h  = bvalid && bready;
      r_h  = rvalid && rready;
      if (aw_h) begin aw_n++; aaddr = awaddr; alen = awlen; chk("awid", 64'(awid), 64'(v.id)); end
      if (ar_h) begin ar_n++; aaddr = araddr; alen = arlen; chk("arid", 64'(arid), 64'(v.id)); end
      if (w_h) begin
        chk("wstrb", 64'(wstrb), 64'(v.exp_strb));
        chk("wdata", 64'(wdata), 64'(32'hA0 + 32'(w_n)));
        chk("w_beat_addr", 64'(dut.u_addr_gen.beat_addr), 64'(model_addr(v.addr, v.size, v.len, v.burst, w_n)));
        if (wlast) begin last_n++; last_at = w_n; end
        w_n++;
      end
      if (rd_valid) begin
        chk("rd_data", 64'(rd_data), 64'(32'hD0 + 32'(r_n)));
        chk("r_beat_addr", 64'(dut.u_addr_gen.beat_addr), 64'(model_addr(v.addr, v.size, v.len, v.burst, r_n)));
        if (rd_last) begin last_n++; last_at = r_n; end
        r_n++;
      end
      if (done) begin done_n++; done_cyc = cyc; dresp = done_resp; derr = done_err; got_done = 1'b1; end
      @(posedge clk); #1;
      if (w_h) wd_data = 32'hA0 + 32'(w_n);
      if (w_h && w_l) begin bvalid = 1'b1; bresp = v.bresp; bid = v.id ^ v.bid_xor; end
      if (b_h) bvalid = 1'b0;
      if (ar_h || r_h) begin
        rbeat = ar_h ? 0 : rbeat + 1;
        if (rbeat > int'(v.len)) rvalid = 1'b0;
        else begin
          rvalid = 1'b1; rdata = 32'hD0 + 32'(rbeat); rid = v.id;
          rresp = v.rresp[2*rbeat +: 2]; rlast = v.rlast_mask[rbeat];
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (done) done_n++;
      if (awvalid || arvalid) begin aw_n += 100; end
      @(posedge clk); #1;
    end
    chk("done_count", 64'(done_n), 64'd1);
    chk("done_cycle", 64'(done_cyc), 64'(v.exp_done_cyc));
    chk("done_resp", 64'(dresp), 64'(v.exp_resp));
    chk("done_err", 64'(derr), 64'(v.exp_err));
    chk("aw_count", 64'(aw_n), 64'(v.exp_aw));
    chk("ar_count", 64'(ar_n), 64'(v.exp_ar));
    if (v.exp_aw + v.exp_ar > 0) begin
      chk("axi_addr", 64'(aaddr), 64'(v.addr));
      chk("axi_len", 64'(alen), 64'(v.len));
    end
    chk("beats", 64'(v.write ? w_n : r_n), 64'(v.exp_beats));
    chk("last_count", 64'(last_n), 64'(v.exp_beats > 0 ? 1 : 0));
    chk("last_index", 64'(last_at), 64'(v.exp_beats > 0 ? int'(v.len) : -1));
    $display("vec %0d %s addr=%0h len=%0d done_cyc=%0d resp=%0d err=%0d beats=%0d",
             vi, v.write ? "WR" : "RD", v.addr, v.len, done_cyc, dresp, derr, v.write ? w_n : r_n);
  endtask

  initial begin
    int wn;
    int dn;
    vecs[0] = '{1'b1, 32'h100,  8'd3, 3'd2, 2'd1, 4'd5, 2'd0, 4'd0, 8'h00, 4'b0000, 1, 0, 4'hF, 4, 2'd0, 1'b0, 8};
    vecs[1] = '{1'b0, 32'h38,   8'd3, 3'd2, 2'd2, 4'd3, 2'd0, 4'd0, 8'h00, 4'b1000, 0, 1, 4'h0, 4, 2'd0, 1'b0, 7};
    vecs[2] = '{1'b1, 32'h1002, 8'd1, 3'd0, 2'd0, 4'd1, 2'd0, 4'd0, 8'h00, 4'b0000, 1, 0, 4'h4, 2, 2'd0, 1'b0, 6};
    vecs[3] = '{1'b1, 32'hFF8,  8'd3, 3'd2, 2'd1, 4'd2, 2'd0, 4'd0, 8'h00, 4'b0000, 0, 0, 4'h0, 0, 2'd2, 1'b1, 2};
    vecs[4] = '{1'b0, 32'h200,  8'd2, 3'd2, 2'd1, 4'd6, 2'd0, 4'd0, 8'h08, 4'b0010, 0, 1, 4'h0, 3, 2'd2, 1'b1, 6};
    vecs[5] = '{1'b1, 32'h0,    8'd0, 3'd2, 2'd1, 4'd4, 2'd3, 4'd0, 8'h00, 4'b0000, 1, 0, 4'hF, 1, 2'd3, 1'b0, 5};
    vecs[6] = '{1'b0, 32'h40,   8'd2, 3'd2, 2'd2, 4'd1, 2'd0, 4'd0, 8'h00, 4'b0000, 0, 0, 4'h0, 0, 2'd2, 1'b1, 2};
    vecs[7] = '{1'b1, 32'h0,    8'd0, 3'd3, 2'd1, 4'd0, 2'd0, 4'd0, 8'h00, 4'b0000, 0, 0, 4'h0, 0, 2'd2, 1'b1, 2};
    vecs[8] = '{1'b0, 32'h80,   8'd0, 3'd2, 2'd0, 4'd7, 2'd0, 4'd0, 8'h01, 4'b0001, 0, 1, 4'h0, 1, 2'd0, 1'b0, 4};
    vecs[9] = '{1'b1, 32'h300,  8'd0, 3'd2, 2'd1, 4'd2, 2'd0, 4'd1, 8'h00, 4'b0000, 1, 0, 4'hF, 1, 2'd0, 1'b1, 5};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    cmd_burst = '0; cmd_id = '0; wd_valid = 1'b1; wd_data = '0;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b0; bid = '0; bresp = '0;
    rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;

    #3;
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reset_ctrl", 64'({awvalid, arvalid, wvalid, wd_ready, bready, rready, done}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("first_idle_cmd_ready", 64'(cmd_ready), 64'd1);
    $display("reset released cmd_ready=%0d", cmd_ready);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Asynchronous reset during beat 1 of a 4-beat write.
    wd_data = 32'hA0;
    drive_cmd(vecs[0]);
    wn = 0;
    for (int c = 0; c < 30 && wn < 1; c++) begin
      @(negedge clk);
      if (wvalid && wready) wn++;
      @(posedge clk); #1;
    end
    chk("reset_seq_beat0", 64'(wn), 64'd1);
    @(negedge clk); #1;
    chk("pre_reset_wvalid", 64'(wvalid), 64'd1);
    rst = 1'b1;
    #1;
    chk("midburst_rst_ctrl", 64'({cmd_ready, awvalid, arvalid, wvalid, wd_ready, wlast, wstrb,
                                  bready, rready, rd_valid, rd_last, done, done_resp, done_err}), 64'd0);
    chk("midburst_rst_awaddr", 64'(awaddr), 64'd0);
    chk("midburst_rst_wdata", 64'(wdata), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("midburst_no_done", 64'(dn), 64'd0);
    chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_reset_state", 64'(dut.state), 64'(IDLE));
    $display("mid-burst reset done_pulses=%0d cmd_ready=%0d", dn, cmd_ready);
    @(posedge clk); #1;

    run_vec(vecs[0], 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
